// File: rtl/mempool_pkg.sv
// Cluster-wide DMA types and constants shared by the DMA frontend blocks.
package mempool_pkg;

    localparam int unsigned AddrWidth  = 32;
    localparam int unsigned DmaIdWidth = 8;

    typedef struct packed {
        logic [AddrWidth-1:0] src;
        logic [AddrWidth-1:0] dst;
        logic [AddrWidth-1:0] num_bytes;
    } dma_req_t;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StDrain
    } dma_sched_state_e;

endpackage

// File: rtl/rr_arb_tree.sv
// Combinational round-robin pick: first requester at or after rr_i, wrapping.
// The caller owns the priority pointer and any grant hold.
module rr_arb_tree #(
    parameter int unsigned NumIn    = 4,
    parameter bit          LockIn   = 1'b0,
    localparam int unsigned IdxWidth = (NumIn > 1) ? $clog2(NumIn) : 1
) (
    input  logic [IdxWidth-1:0] rr_i,
    input  logic [NumIn-1:0]    req_i,
    input  logic                gnt_i,
    output logic [NumIn-1:0]    gnt_o,
    output logic                req_o,
    output logic [IdxWidth-1:0] idx_o
);

    if (LockIn) begin : gen_lock_unsupported
        $error("rr_arb_tree: LockIn is not supported, hold the grant outside");
    end

    int unsigned         cand;
    logic [IdxWidth-1:0] cand_idx;
    logic                found;

    always_comb begin
        gnt_o    = '0;
        idx_o    = '0;
        found    = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int unsigned i = 0; i < NumIn; i++) begin
            cand     = (32'(rr_i) + i) % NumIn;
            cand_idx = IdxWidth'(cand);
            if (!found && req_i[cand_idx]) begin
                found = 1'b1;
                idx_o = cand_idx;
            end
        end
        req_o        = found;
        gnt_o[idx_o] = found & gnt_i;
    end

endmodule

// File: rtl/mempool_dma_scheduler.sv
// Shares the cluster DMA frontend between several control masters: round-robin
// accept, transfer-ID stamping, in-flight limiting, completion counting, barrier drain.
module mempool_dma_scheduler #(
    parameter int unsigned NumRequesters  = 4,
    parameter int unsigned MaxOutstanding = 8,
    parameter int unsigned IdWidth        = mempool_pkg::DmaIdWidth,
    parameter type         dma_req_t      = mempool_pkg::dma_req_t,
    localparam int unsigned OutWidth      = $clog2(MaxOutstanding + 1),
    localparam int unsigned IdxWidth      = (NumRequesters > 1) ? $clog2(NumRequesters) : 1
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  dma_req_t [NumRequesters-1:0]  req_i,
    input  logic [NumRequesters-1:0]      req_valid_i,
    output logic [NumRequesters-1:0]      req_ready_o,
    output logic [IdWidth-1:0]            req_id_o,
    output dma_req_t                      dma_req_o,
    output logic                          dma_req_valid_o,
    input  logic                          dma_req_ready_i,
    input  logic                          trans_complete_i,
    input  logic                          barrier_i,
    output logic                          barrier_done_o,
    output logic [IdWidth-1:0]            completed_id_o,
    output logic [OutWidth-1:0]           outstanding_o,
    output logic                          busy_o
);

    import mempool_pkg::*;

    if (NumRequesters < 2) begin : gen_bad_num_requesters
        $error("mempool_dma_scheduler: NumRequesters must be at least 2");
    end
    if (MaxOutstanding < 1) begin : gen_bad_max_outstanding
        $error("mempool_dma_scheduler: MaxOutstanding must be at least 1");
    end
    if ((2 ** IdWidth) <= (2 * MaxOutstanding)) begin : gen_bad_id_width
        $error("mempool_dma_scheduler: IdWidth too narrow for MaxOutstanding");
    end

    localparam logic [OutWidth-1:0] MaxOut  = OutWidth'(MaxOutstanding);
    localparam logic [IdxWidth-1:0] LastIdx = IdxWidth'(NumRequesters - 1);

    dma_sched_state_e    state_q;
    logic [IdxWidth-1:0] rr_q;
    logic [IdWidth-1:0]  next_id_q;
    logic [IdWidth-1:0]  completed_id_q;
    logic [OutWidth-1:0] outstanding_q;
    logic [OutWidth-1:0] outstanding_d;
    dma_req_t            req_q;
    logic                valid_q;
    logic                done_q;
    logic                barrier_served_q;

    logic                barrier_req;
    logic                can_grant;
    logic                arb_req;
    logic [IdxWidth-1:0] arb_idx;
    logic                accept;
    logic                issue_hs;
    logic                complete;

    // A barrier level is served once; it must drop before it counts again.
    assign barrier_req = barrier_i & ~barrier_served_q;

    // In IDLE nothing is pending on the output register, so only outstanding counts.
    assign can_grant = ~rst_i && (state_q == StIdle) && !barrier_req
                       && (outstanding_q < MaxOut);

    rr_arb_tree #(
        .NumIn  (NumRequesters),
        .LockIn (1'b0)
    ) i_rr_arb (
        .rr_i  (rr_q),
        .req_i (req_valid_i),
        .gnt_i (can_grant),
        .gnt_o (req_ready_o),
        .req_o (arb_req),
        .idx_o (arb_idx)
    );

    assign accept   = can_grant & arb_req;
    assign issue_hs = valid_q & dma_req_ready_i;
    // Completions with nothing in flight are dropped so the counter saturates at zero.
    assign complete = trans_complete_i & (outstanding_q != '0);

    always_comb begin
        outstanding_d = outstanding_q;
        if (issue_hs && !complete) begin
            outstanding_d = outstanding_q + OutWidth'(1);
        end else if (!issue_hs && complete) begin
            outstanding_d = outstanding_q - OutWidth'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q          <= StIdle;
            rr_q             <= '0;
            next_id_q        <= '0;
            completed_id_q   <= '0;
            outstanding_q    <= '0;
            req_q            <= '0;
            valid_q          <= 1'b0;
            done_q           <= 1'b0;
            barrier_served_q <= 1'b0;
        end else begin
            outstanding_q <= outstanding_d;
            done_q        <= 1'b0;
            if (complete) begin
                completed_id_q <= completed_id_q + IdWidth'(1);
            end
            if (!barrier_i) begin
                barrier_served_q <= 1'b0;
            end
            unique case (state_q)
                StIdle: begin
                    if (barrier_req) begin
                        state_q <= StDrain;
                    end else if (accept) begin
                        req_q     <= req_i[arb_idx];
                        valid_q   <= 1'b1;
                        next_id_q <= next_id_q + IdWidth'(1);
                        rr_q      <= (arb_idx == LastIdx) ? '0 : arb_idx + IdxWidth'(1);
                        state_q   <= StIssue;
                    end
                end
                StIssue: begin
                    if (issue_hs) begin
                        valid_q <= 1'b0;
                        state_q <= barrier_req ? StDrain : StIdle;
                    end
                end
                StDrain: begin
                    if (outstanding_d == '0) begin
                        done_q           <= 1'b1;
                        barrier_served_q <= barrier_i;
                        state_q          <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign req_id_o        = next_id_q;
    assign dma_req_o       = req_q;
    assign dma_req_valid_o = valid_q;
    assign barrier_done_o  = done_q;
    assign completed_id_o  = completed_id_q;
    assign outstanding_o   = outstanding_q;
    assign busy_o          = (outstanding_q != '0) | valid_q;

`ifndef SYNTHESIS
    complete_underflow: assert property (@(posedge clk_i) disable iff (rst_i)
        !(trans_complete_i && (outstanding_q == '0)))
        else $error("trans_complete_i pulsed with nothing outstanding");
`endif

endmodule

// File: tb/tb_mempool_dma_scheduler.sv
// Directed bench for mempool_dma_scheduler: default instance plus a narrow-ID
// instance for ID wrap-around.
module tb_mempool_dma_scheduler;

    import mempool_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // default instance: 4 requesters, MaxOutstanding 8, IdWidth 8
    dma_req_t [3:0] req;
    logic [3:0]     req_valid, req_ready;
    logic [7:0]     req_id, completed_id;
    dma_req_t       dma_req;
    logic           dma_valid, dma_ready, complete, barrier, barrier_done, busy;
    logic [3:0]     outstanding;

    // narrow-ID instance: IdWidth 4, MaxOutstanding 4
    dma_req_t [3:0] w_req;
    logic [3:0]     w_req_valid, w_req_ready;
    logic [3:0]     w_req_id, w_completed_id;
    dma_req_t       w_dma_req;
    logic           w_dma_valid, w_dma_ready, w_complete, w_barrier, w_barrier_done, w_busy;
    logic [2:0]     w_outstanding;

    int n_vec = 0;
    int n_err = 0;

    mempool_dma_scheduler u_dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .req_i            (req),
        .req_valid_i      (req_valid),
        .req_ready_o      (req_ready),
        .req_id_o         (req_id),
        .dma_req_o        (dma_req),
        .dma_req_valid_o  (dma_valid),
        .dma_req_ready_i  (dma_ready),
        .trans_complete_i (complete),
        .barrier_i        (barrier),
        .barrier_done_o   (barrier_done),
        .completed_id_o   (completed_id),
        .outstanding_o    (outstanding),
        .busy_o           (busy)
    );

    mempool_dma_scheduler #(
        .NumRequesters  (4),
        .MaxOutstanding (4),
        .IdWidth        (4)
    ) u_wrap (
        .clk_i            (clk),
        .rst_i            (rst),
        .req_i            (w_req),
        .req_valid_i      (w_req_valid),
        .req_ready_o      (w_req_ready),
        .req_id_o         (w_req_id),
        .dma_req_o        (w_dma_req),
        .dma_req_valid_o  (w_dma_valid),
        .dma_req_ready_i  (w_dma_ready),
        .trans_complete_i (w_complete),
        .barrier_i        (w_barrier),
        .barrier_done_o   (w_barrier_done),
        .completed_id_o   (w_completed_id),
        .outstanding_o    (w_outstanding),
        .busy_o           (w_busy)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req_valid   = '0;
        dma_ready   = 1'b0;
        complete    = 1'b0;
        barrier     = 1'b0;
        w_req_valid = '0;
        w_dma_ready = 1'b0;
        w_complete  = 1'b0;
        w_barrier   = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        req_valid = 4'b1111;
        rst = 1'b1;
        step();
        #1;
        n_vec++; if (req_ready !== 4'b0000) begin n_err++;
            $display("FAIL reset_ready: got %b expected 0000", req_ready); end
        n_vec++; if (dma_valid !== 1'b0) begin n_err++;
            $display("FAIL reset_valid: got %b expected 0", dma_valid); end
        n_vec++; if (barrier_done !== 1'b0) begin n_err++;
            $display("FAIL reset_done: got %b expected 0", barrier_done); end
        n_vec++; if (completed_id !== 8'd0) begin n_err++;
            $display("FAIL reset_completed: got %0d expected 0", completed_id); end
        n_vec++; if (outstanding !== 4'd0) begin n_err++;
            $display("FAIL reset_outstanding: got %0d expected 0", outstanding); end
        n_vec++; if (busy !== 1'b0) begin n_err++;
            $display("FAIL reset_busy: got %b expected 0", busy); end
        n_vec++; if (dma_req !== '0) begin n_err++;
            $display("FAIL reset_dma_req: got %h expected 0", dma_req); end
        n_vec++; if (req_id !== 8'd0) begin n_err++;
            $display("FAIL reset_id: got %0d expected 0", req_id); end
        req_valid = '0;
        rst = 1'b0;
        step();
    endtask

    task automatic test_single();
        do_reset();
        req_valid = 4'b0100;
        #1;
        n_vec++; if (req_ready !== 4'b0100) begin n_err++;
            $display("FAIL single_ready: got %b expected 0100", req_ready); end
        n_vec++; if (req_id !== 8'd0) begin n_err++;
            $display("FAIL single_id: got %0d expected 0", req_id); end
        n_vec++; if (dma_valid !== 1'b0) begin n_err++;
            $display("FAIL single_valid_c0: got %b expected 0", dma_valid); end
        step();
        req_valid = '0;
        #1;
        n_vec++; if (dma_valid !== 1'b1) begin n_err++;
            $display("FAIL single_valid_c1: got %b expected 1", dma_valid); end
        n_vec++; if (dma_req !== req[2]) begin n_err++;
            $display("FAIL single_dma_req: got %h expected %h", dma_req, req[2]); end
        n_vec++; if (busy !== 1'b1) begin n_err++;
            $display("FAIL single_busy: got %b expected 1", busy); end
        dma_ready = 1'b1;
        step();
        dma_ready = 1'b0;
        #1;
        n_vec++; if (outstanding !== 4'd1) begin n_err++;
            $display("FAIL single_outstanding: got %0d expected 1", outstanding); end
        n_vec++; if (dma_valid !== 1'b0) begin n_err++;
            $display("FAIL single_valid_drop: got %b expected 0", dma_valid); end
        complete = 1'b1;
        step();
        complete = 1'b0;
        #1;
        n_vec++; if (completed_id !== 8'd1) begin n_err++;
            $display("FAIL single_completed: got %0d expected 1", completed_id); end
        n_vec++; if (outstanding !== 4'd0) begin n_err++;
            $display("FAIL single_out_zero: got %0d expected 0", outstanding); end
        n_vec++; if (busy !== 1'b0) begin n_err++;
            $display("FAIL single_busy_clear: got %b expected 0", busy); end
    endtask

    task automatic test_fairness();
        do_reset();
        req_valid = 4'b1111;
        dma_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            complete = (i > 0);
            #1;
            n_vec++; if (req_ready !== 4'(1 << (i % 4))) begin n_err++;
                $display("FAIL fair_ready[%0d]: got %b expected %b", i, req_ready,
                         4'(1 << (i % 4))); end
            n_vec++; if (req_id !== 8'(i)) begin n_err++;
                $display("FAIL fair_id[%0d]: got %0d expected %0d", i, req_id, i); end
            step();
            complete = 1'b0;
            if (i == 4) req_valid = '0;
            #1;
            n_vec++; if (dma_req !== req[i % 4]) begin n_err++;
                $display("FAIL fair_dma_req[%0d]: got %h expected %h", i, dma_req,
                         req[i % 4]); end
            n_vec++; if (req_ready !== 4'b0000) begin n_err++;
                $display("FAIL fair_issue_ready[%0d]: got %b expected 0000", i, req_ready); end
            step();
        end
        complete = 1'b1;
        step();
        complete = 1'b0;
        #1;
        n_vec++; if (completed_id !== 8'd5) begin n_err++;
            $display("FAIL fair_completed: got %0d expected 5", completed_id); end
        n_vec++; if (outstanding !== 4'd0) begin n_err++;
            $display("FAIL fair_outstanding: got %0d expected 0", outstanding); end
    endtask

    task automatic test_throttle();
        do_reset();
        req_valid = 4'b1111;
        dma_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            n_vec++; if (req_id !== 8'(i)) begin n_err++;
                $display("FAIL thr_id[%0d]: got %0d expected %0d", i, req_id, i); end
            n_vec++; if (req_ready !== 4'(1 << (i % 4))) begin n_err++;
                $display("FAIL thr_ready[%0d]: got %b expected %b", i, req_ready,
                         4'(1 << (i % 4))); end
            step();
            step();
        end
        #1;
        n_vec++; if (outstanding !== 4'd8) begin n_err++;
            $display("FAIL thr_full: got %0d expected 8", outstanding); end
        for (int c = 0; c < 3; c++) begin
            n_vec++; if (req_ready !== 4'b0000 || dma_valid !== 1'b0) begin n_err++;
                $display("FAIL thr_blocked[%0d]: got ready %b valid %b expected 0000 0",
                         c, req_ready, dma_valid); end
            step();
        end
        complete = 1'b1;
        #1;
        n_vec++; if (req_ready !== 4'b0000) begin n_err++;
            $display("FAIL thr_same_cycle: got %b expected 0000", req_ready); end
        step();
        complete = 1'b0;
        #1;
        n_vec++; if (req_ready !== 4'b0001) begin n_err++;
            $display("FAIL thr_resume_ready: got %b expected 0001", req_ready); end
        n_vec++; if (req_id !== 8'd8) begin n_err++;
            $display("FAIL thr_resume_id: got %0d expected 8", req_id); end
        n_vec++; if (outstanding !== 4'd7) begin n_err++;
            $display("FAIL thr_resume_out: got %0d expected 7", outstanding); end
        req_valid = '0;
        step();
    endtask

    task automatic test_backpressure();
        do_reset();
        req_valid = 4'b0010;
        #1;
        n_vec++; if (req_ready !== 4'b0010) begin n_err++;
            $display("FAIL bp_ready: got %b expected 0010", req_ready); end
        step();
        req_valid = 4'b1000;
        for (int c = 0; c < 5; c++) begin
            #1;
            n_vec++; if (dma_valid !== 1'b1 || dma_req !== req[1]) begin n_err++;
                $display("FAIL bp_hold[%0d]: got valid %b req %h expected 1 %h", c, dma_valid,
                         dma_req, req[1]); end
            n_vec++; if (req_ready !== 4'b0000 || outstanding !== 4'd0) begin n_err++;
                $display("FAIL bp_stall[%0d]: got ready %b out %0d expected 0000 0", c,
                         req_ready, outstanding); end
            step();
        end
        dma_ready = 1'b1;
        step();
        dma_ready = 1'b0;
        #1;
        n_vec++; if (outstanding !== 4'd1 || dma_valid !== 1'b0) begin n_err++;
            $display("FAIL bp_handshake: got out %0d valid %b expected 1 0", outstanding,
                     dma_valid); end
        n_vec++; if (req_ready !== 4'b1000 || req_id !== 8'd1) begin n_err++;
            $display("FAIL bp_next_grant: got ready %b id %0d expected 1000 1", req_ready,
                     req_id); end
        step();
        req_valid = '0;
        #1;
        n_vec++; if (outstanding !== 4'd1 || dma_req !== req[3]) begin n_err++;
            $display("FAIL bp_counted_once: got out %0d req %h expected 1 %h", outstanding,
                     dma_req, req[3]); end
    endtask

    task automatic test_barrier();
        do_reset();
        req_valid = 4'b0001;
        dma_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            step();
        end
        barrier = 1'b1;
        #1;
        n_vec++; if (req_ready !== 4'b0000 || outstanding !== 4'd3) begin n_err++;
            $display("FAIL bar_block: got ready %b out %0d expected 0000 3", req_ready,
                     outstanding); end
        step();
        for (int k = 0; k < 3; k++) begin
            complete = 1'b1;
            #1;
            n_vec++; if (req_ready !== 4'b0000 || barrier_done !== 1'b0) begin n_err++;
                $display("FAIL bar_drain[%0d]: got ready %b done %b expected 0000 0", k,
                         req_ready, barrier_done); end
            step();
            complete = 1'b0;
        end
        #1;
        n_vec++; if (barrier_done !== 1'b1 || outstanding !== 4'd0) begin n_err++;
            $display("FAIL bar_done: got done %b out %0d expected 1 0", barrier_done,
                     outstanding); end
        n_vec++; if (completed_id !== 8'd3) begin n_err++;
            $display("FAIL bar_completed: got %0d expected 3", completed_id); end
        n_vec++; if (req_ready !== 4'b0001 || req_id !== 8'd3) begin n_err++;
            $display("FAIL bar_resume: got ready %b id %0d expected 0001 3", req_ready,
                     req_id); end
        step();
        req_valid = '0;
        #1;
        n_vec++; if (barrier_done !== 1'b0) begin n_err++;
            $display("FAIL bar_pulse_width: got %b expected 0", barrier_done); end
        barrier = 1'b0;
        step();
    endtask

    task automatic test_barrier_idle();
        do_reset();
        barrier = 1'b1;
        step();
        #1;
        n_vec++; if (barrier_done !== 1'b0) begin n_err++;
            $display("FAIL bidle_c1: got %b expected 0", barrier_done); end
        step();
        #1;
        n_vec++; if (barrier_done !== 1'b1) begin n_err++;
            $display("FAIL bidle_c2: got %b expected 1", barrier_done); end
        step();
        #1;
        n_vec++; if (barrier_done !== 1'b0) begin n_err++;
            $display("FAIL bidle_c3: got %b expected 0", barrier_done); end
        step();
        #1;
        n_vec++; if (barrier_done !== 1'b0) begin n_err++;
            $display("FAIL bidle_rearm: got %b expected 0", barrier_done); end
        req_valid = 4'b0100;
        #1;
        n_vec++; if (req_ready !== 4'b0100) begin n_err++;
            $display("FAIL bidle_grant: got %b expected 0100", req_ready); end
        req_valid = '0;
        barrier = 1'b0;
        step();
    endtask

    task automatic test_wrap();
        do_reset();
        w_req_valid = 4'b1111;
        w_dma_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            #1;
            n_vec++; if (w_req_id !== 4'(i % 16)) begin n_err++;
                $display("FAIL wrap_id[%0d]: got %0d expected %0d", i, w_req_id, i % 16); end
            n_vec++; if (w_req_ready !== 4'(1 << (i % 4))) begin n_err++;
                $display("FAIL wrap_ready[%0d]: got %b expected %b", i, w_req_ready,
                         4'(1 << (i % 4))); end
            step();
            w_complete = (i > 0);
            if (i == 19) w_req_valid = '0;
            #1;
            n_vec++; if (w_dma_valid !== 1'b1 || w_dma_req !== w_req[i % 4]) begin n_err++;
                $display("FAIL wrap_issue[%0d]: got valid %b req %h expected 1 %h", i,
                         w_dma_valid, w_dma_req, w_req[i % 4]); end
            step();
            w_complete = 1'b0;
            #1;
            n_vec++; if (w_outstanding !== 3'd1) begin n_err++;
                $display("FAIL wrap_net_zero[%0d]: got %0d expected 1", i, w_outstanding); end
        end
        w_complete = 1'b1;
        step();
        w_complete = 1'b0;
        #1;
        n_vec++; if (w_completed_id !== 4'd4) begin n_err++;
            $display("FAIL wrap_completed: got %0d expected 4", w_completed_id); end
        n_vec++; if (w_outstanding !== 3'd0) begin n_err++;
            $display("FAIL wrap_out_zero: got %0d expected 0", w_outstanding); end
    endtask

    initial begin
        for (int k = 0; k < 4; k++) begin
            req[k]   = '{src: 32'h1000_0000 + 32'(k), dst: 32'h2000_0000 + 32'(k * 16),
                         num_bytes: 32'(64 * (k + 1))};
            w_req[k] = '{src: 32'h3000_0000 + 32'(k), dst: 32'h4000_0000 + 32'(k * 16),
                         num_bytes: 32'(32 * (k + 1))};
        end
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_single();
        test_fairness();
        test_throttle();
        test_backpressure();
        test_barrier();
        test_barrier_idle();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation did not finish");
    end

endmodule
